// File: rtl/tug_pkg.sv
// tug_pkg: shared types and helpers for the tug-of-war playfield.
package tug_pkg;

    typedef enum logic {
        PLAY,
        WIN
    } field_state_t;

    typedef enum logic {
        WIN_LEFT,
        WIN_RIGHT
    } winner_t;

    // Width of the win-display hold counter.
    localparam int unsigned HOLD_W = 8;

    // Index of the centre light for an odd-sized bar.
    function automatic int unsigned centre_index(input int unsigned num_lights);
        return (num_lights - 1) / 2;
    endfunction

endpackage

// File: rtl/tug_score_counter.sv
// tug_score_counter: saturating per-player win counter, CE-gated, async reset.
module tug_score_counter #(
    parameter int unsigned SCORE_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   ce,
    input  logic                   inc,
    output logic [SCORE_WIDTH-1:0] count
);

    // Count one win per enabled increment, holding at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (ce && inc && (count != '1)) begin
            count <= count + SCORE_WIDTH'(1);
        end
    end

endmodule

// File: rtl/tug_field.sv
// tug_field: index-based tug-of-war playfield with edge-win detection,
// timed auto-serve and, when TUG_SCORE_EN is defined, per-player score
// counters (SCORE_WIDTH parameter and score_left/score_right ports).
module tug_field
    import tug_pkg::*;
#(
    parameter int unsigned NUM_LIGHTS  = 9,
    parameter int unsigned HOLD_TICKS  = 4
`ifdef TUG_SCORE_EN
    ,
    parameter int unsigned SCORE_WIDTH = 4
`endif
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   CE,
    input  logic                   left_press,
    input  logic                   right_press,
    input  logic                   restart,
    output logic [NUM_LIGHTS-1:0]  lights,
    output logic                   win_left,
    output logic                   win_right,
    output logic                   round_active
`ifdef TUG_SCORE_EN
    ,
    output logic [SCORE_WIDTH-1:0] score_left,
    output logic [SCORE_WIDTH-1:0] score_right
`endif
);

    localparam int unsigned      PW        = $clog2(NUM_LIGHTS);
    localparam logic [PW-1:0]     POS_MAX   = PW'(NUM_LIGHTS - 1);
    localparam logic [PW-1:0]     POS_CTR   = PW'(centre_index(NUM_LIGHTS));
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

    field_state_t      state, state_nxt;
    winner_t           winner, winner_nxt;
    logic [PW-1:0]     pos, pos_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              move_l, move_r;

    // State register: FSM state, light index, winner and hold counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= PLAY;
            pos      <= POS_CTR;
            winner   <= WIN_LEFT;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            pos      <= pos_nxt;
            winner   <= winner_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // Next-state logic: restart first, then CE-gated play/hold progression.
    always_comb begin
        state_nxt  = state;
        pos_nxt    = pos;
        winner_nxt = winner;
        hold_nxt   = hold_cnt;
        move_l     = CE && left_press && !right_press;
        move_r     = CE && right_press && !left_press;

        if (restart) begin
            state_nxt = PLAY;
            pos_nxt   = POS_CTR;
            hold_nxt  = '0;
        end else if (CE) begin
            case (state)
                PLAY: begin
                    if (move_l) begin
                        if (pos == POS_MAX) begin
                            state_nxt  = WIN;
                            winner_nxt = WIN_LEFT;
                            hold_nxt   = '0;
                        end else begin
                            pos_nxt = pos + PW'(1);
                        end
                    end else if (move_r) begin
                        if (pos == '0) begin
                            state_nxt  = WIN;
                            winner_nxt = WIN_RIGHT;
                            hold_nxt   = '0;
                        end else begin
                            pos_nxt = pos - PW'(1);
                        end
                    end
                end
                WIN: begin
                    // The tick that completes the hold also serves, so the
                    // counter is compared before it would reach HOLD_TICKS.
                    if (hold_cnt == HOLD_LAST) begin
                        state_nxt = PLAY;
                        pos_nxt   = POS_CTR;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt = hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    state_nxt = PLAY;
                    pos_nxt   = POS_CTR;
                    hold_nxt  = '0;
                end
            endcase
        end
    end

    // Output decode from registered state only.
    always_comb begin
        lights       = '0;
        for (int unsigned i = 0; i < NUM_LIGHTS; i++) begin
            lights[i] = (state == PLAY) && (pos == PW'(i));
        end
        round_active = (state == PLAY);
        win_left     = (state == WIN) && (winner == WIN_LEFT);
        win_right    = (state == WIN) && (winner == WIN_RIGHT);
    end

`ifdef TUG_SCORE_EN
    logic inc_left, inc_right;

    // A score is taken on the tick that moves PLAY into WIN.
    always_comb begin
        inc_left  = (state == PLAY) && (state_nxt == WIN) && (winner_nxt == WIN_LEFT);
        inc_right = (state == PLAY) && (state_nxt == WIN) && (winner_nxt == WIN_RIGHT);
    end

    tug_score_counter #(
        .SCORE_WIDTH(SCORE_WIDTH)
    ) u_score_left (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (CE),
        .inc     (inc_left),
        .count   (score_left)
    );

    tug_score_counter #(
        .SCORE_WIDTH(SCORE_WIDTH)
    ) u_score_right (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (CE),
        .inc     (inc_right),
        .count   (score_right)
    );
`endif

endmodule

// File: tb/tb_tug_field.sv
// tb_tug_field: directed self-checking bench for tug_field (NUM_LIGHTS=5,
// HOLD_TICKS=4, SCORE_WIDTH=2 when TUG_SCORE_EN is defined).
module tb_tug_field;

    logic       clk;
    logic       reset_n;
    logic       CE;
    logic       left_press;
    logic       right_press;
    logic       restart;
    logic [4:0] lights;
    logic       win_left;
    logic       win_right;
    logic       round_active;
`ifdef TUG_SCORE_EN
    logic [1:0] score_left;
    logic [1:0] score_right;
`endif

    int checks   = 0;
    int failures = 0;

    tug_field #(
        .NUM_LIGHTS (5),
        .HOLD_TICKS (4)
`ifdef TUG_SCORE_EN
        ,
        .SCORE_WIDTH(2)
`endif
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .CE           (CE),
        .left_press   (left_press),
        .right_press  (right_press),
        .restart      (restart),
        .lights       (lights),
        .win_left     (win_left),
        .win_right    (win_right),
        .round_active (round_active)
`ifdef TUG_SCORE_EN
        ,
        .score_left   (score_left),
        .score_right  (score_right)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic ce, input logic l, input logic r, input logic rs);
        CE          = ce;
        left_press  = l;
        right_press = r;
        restart     = rs;
        @(posedge clk);
        #1;
        CE          = 1'b0;
        left_press  = 1'b0;
        right_press = 1'b0;
        restart     = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; CE = 1'b0; left_press = 1'b0; right_press = 1'b0; restart = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        checks++;
        if (lights !== 5'b00100) begin failures++; $display("FAIL reset_lights: got %b want %b", lights, 5'b00100); end
        checks++;
        if (round_active !== 1'b1) begin failures++; $display("FAIL reset_round_active: got %b want 1", round_active); end
        checks++;
        if ({win_left, win_right} !== 2'b00) begin failures++; $display("FAIL reset_win: got %b want 00", {win_left, win_right}); end
`ifdef TUG_SCORE_EN
        checks++;
        if ({score_left, score_right} !== 4'b0000) begin failures++; $display("FAIL reset_scores: got %b want 0000", {score_left, score_right}); end
`endif
    endtask

    task automatic test_left_moves();
        step(1, 1, 0, 0);
        checks++;
        if (lights !== 5'b01000) begin failures++; $display("FAIL left_move1: got %b want %b", lights, 5'b01000); end
        step(1, 1, 0, 0);
        checks++;
        if (lights !== 5'b10000) begin failures++; $display("FAIL left_move2: got %b want %b", lights, 5'b10000); end
        step(1, 1, 0, 0);
        checks++;
        if ({lights, win_left, win_right, round_active} !== 8'b00000_100) begin
            failures++; $display("FAIL left_win: got lights=%b wl=%b wr=%b ra=%b want 00000 1 0 0", lights, win_left, win_right, round_active);
        end
`ifdef TUG_SCORE_EN
        checks++;
        if (score_left !== 2'd1) begin failures++; $display("FAIL left_win_score: got %0d want 1", score_left); end
`endif
    endtask

    task automatic test_hold();
        // Three CE ticks with presses: still WIN, no motion.
        for (int i = 0; i < 3; i++) begin
            step(1, (i == 1), (i != 1), 0);
            checks++;
            if ({lights, win_left, round_active} !== 7'b00000_10) begin
                failures++; $display("FAIL hold_tick%0d: got lights=%b wl=%b ra=%b want 00000 1 0", i + 1, lights, win_left, round_active);
            end
        end
        // CE low freezes the hold counter.
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0);
            checks++;
            if ({lights, win_left} !== 6'b00000_1) begin
                failures++; $display("FAIL hold_frozen%0d: got lights=%b wl=%b want 00000 1", i, lights, win_left);
            end
        end
        step(1, 0, 0, 0);
        checks++;
        if ({lights, win_left, win_right, round_active} !== 8'b00100_001) begin
            failures++; $display("FAIL hold_serve: got lights=%b wl=%b wr=%b ra=%b want 00100 0 0 1", lights, win_left, win_right, round_active);
        end
    endtask

    task automatic test_no_move();
        for (int i = 0; i < 10; i++) begin
            if (i < 5) step(1, 1, 1, 0);
            else       step(0, (i[0] == 1'b1), (i[0] == 1'b0), 0);
            checks++;
            if (lights !== 5'b00100) begin failures++; $display("FAIL no_move%0d: got %b want %b", i, lights, 5'b00100); end
        end
    endtask

    task automatic test_restart();
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        checks++;
        if (lights !== 5'b00001) begin failures++; $display("FAIL restart_setup: got %b want %b", lights, 5'b00001); end
        step(0, 0, 0, 1);
        checks++;
        if (lights !== 5'b00100) begin failures++; $display("FAIL restart_at_edge: got %b want %b", lights, 5'b00100); end
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        checks++;
        if ({lights, win_left, win_right} !== 7'b00000_01) begin
            failures++; $display("FAIL right_win: got lights=%b wl=%b wr=%b want 00000 0 1", lights, win_left, win_right);
        end
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        checks++;
        if ({lights, win_left, win_right, round_active} !== 8'b00100_001) begin
            failures++; $display("FAIL restart_in_win: got lights=%b wl=%b wr=%b ra=%b want 00100 0 0 1", lights, win_left, win_right, round_active);
        end
`ifdef TUG_SCORE_EN
        checks++;
        if ({score_left, score_right} !== {2'd1, 2'd1}) begin
            failures++; $display("FAIL restart_scores: got L=%0d R=%0d want L=1 R=1", score_left, score_right);
        end
`endif
        step(1, 1, 0, 1);
        checks++;
        if (lights !== 5'b00100) begin failures++; $display("FAIL restart_priority: got %b want %b", lights, 5'b00100); end
    endtask

    task automatic test_score_saturation();
        int exp_sc[4] = '{2, 3, 3, 3};
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 1, 0);
            step(1, 0, 1, 0);
            step(1, 0, 1, 0);
            checks++;
            if ({lights, win_right} !== 6'b00000_1) begin
                failures++; $display("FAIL sat_round%0d_win: got lights=%b wr=%b want 00000 1", k, lights, win_right);
            end
`ifdef TUG_SCORE_EN
            checks++;
            if (score_right !== 2'(exp_sc[k])) begin
                failures++; $display("FAIL sat_round%0d_score: got %0d want %0d", k, score_right, exp_sc[k]);
            end
`endif
            repeat (4) step(1, 0, 0, 0);
            checks++;
            if (lights !== 5'b00100) begin failures++; $display("FAIL sat_round%0d_serve: got %b want %b", k, lights, 5'b00100); end
        end
    endtask

    task automatic test_reset_mid_hold();
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        checks++;
        if (win_left !== 1'b1) begin failures++; $display("FAIL midhold_setup: got wl=%b want 1", win_left); end
`ifdef TUG_SCORE_EN
        checks++;
        if (score_left !== 2'd2) begin failures++; $display("FAIL midhold_score: got %0d want 2", score_left); end
`endif
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        reset_n = 1'b0;
        #2;
        checks++;
        if ({lights, win_left, win_right, round_active} !== 8'b00100_001) begin
            failures++; $display("FAIL async_reset: got lights=%b wl=%b wr=%b ra=%b want 00100 0 0 1", lights, win_left, win_right, round_active);
        end
`ifdef TUG_SCORE_EN
        checks++;
        if ({score_left, score_right} !== 4'b0000) begin
            failures++; $display("FAIL async_reset_scores: got %b want 0000", {score_left, score_right});
        end
`endif
        reset_n = 1'b1;
        step(0, 0, 0, 0);
        checks++;
        if (lights !== 5'b00100) begin failures++; $display("FAIL post_reset_idle: got %b want %b", lights, 5'b00100); end
        step(1, 1, 0, 0);
        checks++;
        if (lights !== 5'b01000) begin failures++; $display("FAIL post_reset_move: got %b want %b", lights, 5'b01000); end
    endtask

    initial begin
        test_reset();
        test_left_moves();
        test_hold();
        test_no_move();
        test_restart();
        test_score_saturation();
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
